// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap/clear stopwatch controller over a cascade of BCD decade digits.
// Optional AUTO_STOP_EN: saturate at all-9s and force PAUSE instead of wrapping.
module stopwatch_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 10,
  parameter int TICK_W     = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start_stop,
  input  logic                    lap,
  input  logic                    clear,
  output logic                    running,
  output logic                    paused,
  output logic                    lap_hold,
  output logic                    tick,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    overflow
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;

  localparam logic [TICK_W-1:0] PRESC_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0] PRESC_ONE  = TICK_W'(1);

  logic [1:0]              state_q, state_d;
  logic [TICK_W-1:0]       presc_q, presc_d;
  logic [4*NUM_DIGITS-1:0] count_q, count_d;
  logic [4*NUM_DIGITS-1:0] snap_q, snap_d;
  logic                    lap_hold_q, lap_hold_d;
  logic                    overflow_q, overflow_d;

  logic                    tick_now;
  logic [4*NUM_DIGITS-1:0] count_inc;
  logic                    wrap_all;

  assign tick_now = (state_q == S_RUN) && (presc_q == PRESC_LAST);

  // Ripple enable: each digit sees the tick only while every lower digit is 9.
  always_comb begin
    logic en;
    en        = tick_now;
    count_inc = count_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (en) begin
        if (count_q[4*i +: 4] >= 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
        end
      end
      en = en && (count_q[4*i +: 4] == 4'd9);
    end
    wrap_all = en;
  end

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    count_d    = count_q;
    snap_d     = snap_q;
    lap_hold_d = lap_hold_q;
    overflow_d = overflow_q;

    if (state_q == S_RUN) begin
      presc_d = tick_now ? '0 : presc_q + PRESC_ONE;
      if (tick_now) begin
        count_d = count_inc;
        if (wrap_all) begin
          overflow_d = 1'b1;
`ifdef AUTO_STOP_EN
          count_d = count_q;
          state_d = S_PAUSE;
`endif
        end
      end
    end

    // clear outranks start_stop, which outranks lap; clear has no effect in RUN.
    if (clear && (state_q != S_RUN)) begin
      state_d    = S_IDLE;
      presc_d    = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      lap_hold_d = 1'b0;
    end else if (start_stop) begin
      state_d = (state_q == S_RUN) ? S_PAUSE : S_RUN;
    end else if (lap) begin
      if ((state_q == S_RUN) && !lap_hold_q) begin
        snap_d     = count_q;
        lap_hold_d = 1'b1;
      end else if ((state_q != S_IDLE) && lap_hold_q) begin
        lap_hold_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      presc_q    <= '0;
      count_q    <= '0;
      snap_q     <= '0;
      lap_hold_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      count_q    <= count_d;
      snap_q     <= snap_d;
      lap_hold_q <= lap_hold_d;
      overflow_q <= overflow_d;
    end
  end

  assign running  = (state_q == S_RUN);
  assign paused   = (state_q == S_PAUSE);
  assign lap_hold = lap_hold_q;
  assign tick     = tick_now;
  assign digits   = lap_hold_q ? snap_q : count_q;
  assign overflow = overflow_q;

endmodule
